// File: rtl/ptp_pps_io_if.sv
// ptp_pps_io_if
//   Timestamp hand-off between ptp_pps_io and the register block.
//   pts_std_o : compensated {sec[47:0], ns[31:0]} of the last captured pps_i edge
//   pts_vld_o : timestamp pending, held until pts_ack_i
//   pts_ovf_o : sticky, an edge was dropped while a timestamp was pending
//   pts_cnt_o : number of captured edges (16-bit wrap)
//   pts_ack_i : single-cycle acknowledge from the register block
//   master = timestamp producer (ptp_pps_io), slave = register block.
interface ptp_pps_io_if;
  logic [79:0] pts_std_o;
  logic        pts_vld_o;
  logic        pts_ovf_o;
  logic [15:0] pts_cnt_o;
  logic        pts_ack_i;

  modport master (
    output pts_std_o, pts_vld_o, pts_ovf_o, pts_cnt_o,
    input  pts_ack_i
  );

  modport slave (
    input  pts_std_o, pts_vld_o, pts_ovf_o, pts_cnt_o,
    output pts_ack_i
  );
endinterface

// File: rtl/ptp_pps_io.sv
// ptp_pps_io
//   PPS output generation and PPS input timestamping, downstream of the RTC.
//   clk          : core clock (156.25 MHz)
//   rst_n        : asynchronous active-low reset
//   rtc_std_i    : current RTC time {sec[47:0], ns[31:0]}
//   pps_en_i     : enables pps_o generation
//   pps_width_i  : pps_o high time in ns, 0 selects DEF_PW_NS
//   pps_i        : external PPS, asynchronous to clk
//   cap_en_i     : enables pps_i timestamp capture
//   pps_o        : generated PPS pulse, rises one clk after a second rollover
//   pts          : timestamp hand-off (see ptp_pps_io_if)
module ptp_pps_io #(
  parameter logic [31:0] NS_PER_SEC   = 32'd1_000_000_000,
  parameter logic [31:0] SYNC_COMP_NS = 32'd19,
  parameter logic [31:0] DEF_PW_NS    = 32'd100_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [79:0]        rtc_std_i,
  input  logic               pps_en_i,
  input  logic [31:0]        pps_width_i,
  input  logic               pps_i,
  input  logic               cap_en_i,
  output logic               pps_o,
  ptp_pps_io_if.master       pts
);

  typedef enum logic {IDLE, HIGH} state_t;

  // Subtract the synchronizer latency from a captured time, borrowing a
  // second when the nanosecond field would go negative (sec wraps modulo 2^48).
  function automatic logic [79:0] comp_ts(input logic [79:0] t);
    logic [47:0] s;
    logic [31:0] n;
    s = t[79:32];
    n = t[31:0];
    if (n >= SYNC_COMP_NS) begin
      n = n - SYNC_COMP_NS;
    end else begin
      n = n + NS_PER_SEC - SYNC_COMP_NS;
      s = s - 48'd1;
    end
    return {s, n};
  endfunction

  logic [47:0] sec_p0;
  logic [31:0] ns_p0;
  logic [47:0] prev_sec_p1;
  logic [31:0] prev_ns_p1;
  logic        rollover;
  logic [31:0] pw;
  state_t      state, state_nxt;

  logic        pps_meta_p0, pps_sync_p1, pps_dly_p2;
  logic        edge_p2, take, drop;

  assign sec_p0 = rtc_std_i[79:32];
  assign ns_p0  = rtc_std_i[31:0];

  // Only a natural +1 second step with ns wrapping counts; software loads or
  // clears that move sec any other way are ignored. prev resets to zero, so
  // the first cycle out of reset can never satisfy ns < prev_ns.
  assign rollover = (sec_p0 != prev_sec_p1) && (ns_p0 < prev_ns_p1) &&
                    (sec_p0 == prev_sec_p1 + 48'd1);

  assign pw = (pps_width_i == 32'd0) ? DEF_PW_NS : pps_width_i;

  // Stage p0 -> p1: previous RTC time for rollover detection, pps_o state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_sec_p1 <= '0;
      prev_ns_p1  <= '0;
      state       <= IDLE;
    end else begin
      prev_sec_p1 <= sec_p0;
      prev_ns_p1  <= ns_p0;
      state       <= state_nxt;
    end
  end

  // A rollover while HIGH keeps the pulse up, so widths >= one second give a
  // continuous high level with no gap at the second boundary.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pps_en_i && rollover) state_nxt = HIGH;
      HIGH: begin
        if (!pps_en_i)          state_nxt = IDLE;
        else if (rollover)      state_nxt = HIGH;
        else if (ns_p0 >= pw)   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pps_o = (state == HIGH);

  // Edge while a timestamp is pending is dropped unless the register block
  // acknowledges in the same cycle, in which case the new one replaces it.
  assign edge_p2 = pps_sync_p1 & ~pps_dly_p2 & cap_en_i;
  assign take    = edge_p2 & (~pts.pts_vld_o | pts.pts_ack_i);
  assign drop    = edge_p2 & pts.pts_vld_o & ~pts.pts_ack_i;

  // Stage p0 -> p2: pps_i synchronizer and edge-detect delay
  // Stage p2 -> out: compensated timestamp and handshake state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pps_meta_p0   <= 1'b0;
      pps_sync_p1   <= 1'b0;
      pps_dly_p2    <= 1'b0;
      pts.pts_std_o <= '0;
      pts.pts_vld_o <= 1'b0;
      pts.pts_ovf_o <= 1'b0;
      pts.pts_cnt_o <= '0;
    end else begin
      pps_meta_p0 <= pps_i;
      pps_sync_p1 <= pps_meta_p0;
      pps_dly_p2  <= pps_sync_p1;

      if (take) begin
        pts.pts_std_o <= comp_ts(rtc_std_i);
        pts.pts_cnt_o <= pts.pts_cnt_o + 16'd1;
      end

      if (take)                pts.pts_vld_o <= 1'b1;
      else if (pts.pts_ack_i)  pts.pts_vld_o <= 1'b0;

      if (drop)                pts.pts_ovf_o <= 1'b1;
      else if (pts.pts_ack_i)  pts.pts_ovf_o <= 1'b0;
    end
  end

endmodule
